// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder/subtractor sequencer. A single 1-bit full-adder cell,
// built from two half adders, is reused for every operand bit, LSB first.
// Subtraction uses a + ~b + 1: the inverted operand is loaded and the
// carry flop is preset to 1.

module halfadder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_out_r;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] res_sr_r;
  logic [CNT_W-1:0] count_r;
  logic             carry_r;

  logic             prop_s;
  logic             gen_s;
  logic             bit_sum_s;
  logic             carry_prop_s;
  logic             carry_nxt_s;
  logic             last_bit_s;

  // Shared full-adder cell: two half adders plus an OR on their carries.
  halfadder u_ha_ab (
    .x (a_sr_r[0]),
    .y (b_sr_r[0]),
    .s (prop_s),
    .c (gen_s)
  );

  halfadder u_ha_c (
    .x (prop_s),
    .y (carry_r),
    .s (bit_sum_s),
    .c (carry_prop_s)
  );

  assign carry_nxt_s = gen_s | carry_prop_s;
  assign last_bit_s  = (count_r == LAST_CNT);

  // Next-state decode; start is only looked at while idle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_bit_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register with registered busy/done derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
      done_r  <= (state_nxt_s == DONE);
    end
  end

  // Operand shift registers, bit counter, carry flop and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_r      <= '0;
      b_sr_r      <= '0;
      res_sr_r    <= '0;
      count_r     <= '0;
      carry_r     <= 1'b0;
      sum_r       <= '0;
      carry_out_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_sr_r   <= a;
            b_sr_r   <= sub ? ~b : b;
            carry_r  <= sub;
            count_r  <= '0;
            res_sr_r <= '0;
          end
        end
        RUN: begin
          res_sr_r <= {bit_sum_s, res_sr_r[WIDTH-1:1]};
          a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
          b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
          carry_r  <= carry_nxt_s;
          count_r  <= count_r + CNT_ONE;
          // Result becomes visible only once the final bit is formed.
          if (last_bit_s) begin
            sum_r       <= {bit_sum_s, res_sr_r[WIDTH-1:1]};
            carry_out_r <= carry_nxt_s;
          end
        end
        DONE: begin
          count_r <= '0;
        end
        default: begin
          count_r <= '0;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign sum       = sum_r;
  assign carry_out = carry_out_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8). Stimulus pushes the
// hand-computed result and its expected completion cycle; an independent
// negedge monitor checks every cycle's outputs against the schedule.

module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       carry_out;

  typedef struct {
    logic [7:0] s;
    logic       c;
    int         cyc;
  } exp_t;

  exp_t       q[$];
  int         cyc;
  int         busy_lo;
  int         busy_hi;
  logic [7:0] last_sum;
  logic       last_c;
  int         checks;
  int         errors;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: per-cycle check of busy, done timing, result and hold behaviour.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_sum", {24'd0, sum}, 32'd0);
      chk("rst_cout", {31'd0, carry_out}, 32'd0);
    end else begin
      chk("busy", {31'd0, busy}, {31'd0, (cyc >= busy_lo && cyc <= busy_hi)});
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("sum", {24'd0, sum}, {24'd0, e.s});
          chk("carry_out", {31'd0, carry_out}, {31'd0, e.c});
          last_sum = e.s;
          last_c   = e.c;
        end
      end else begin
        chk("sum_hold", {24'd0, sum}, {24'd0, last_sum});
        chk("cout_hold", {31'd0, carry_out}, {31'd0, last_c});
        if (q.size() != 0 && cyc >= q[0].cyc) begin
          chk("done_missing", 32'd0, 32'd1);
          void'(q.pop_front());
        end
      end
    end
  end

  // Issue one operation from IDLE; returns one cycle after the accept edge.
  task automatic issue(input logic [7:0] ta, input logic [7:0] tb_v,
                       input logic ts, input logic [8:0] expv);
    exp_t e;
    a      = ta;
    b      = tb_v;
    sub    = ts;
    start  = 1'b1;
    e.s    = expv[7:0];
    e.c    = expv[8];
    e.cyc  = cyc + 9;
    q.push_back(e);
    busy_lo = cyc + 1;
    busy_hi = cyc + 9;
    @(posedge clk);
    #2;
    start = 1'b0;
    a     = $urandom_range(255, 0);
    b     = $urandom_range(255, 0);
    sub   = $urandom_range(1, 0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    busy_lo  = 1;
    busy_hi  = 0;
    last_sum = 8'h00;
    last_c   = 1'b0;
    rst_n    = 1'b0;
    start    = 1'b1;
    sub      = 1'b0;
    a        = 8'hFF;
    b        = 8'h01;

    // Reset held with start asserted.
    repeat (2) @(posedge clk);
    #2;
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    // Simple add, then back-to-back at earliest acceptance.
    issue(8'd3, 8'd5, 1'b0, {1'b0, 8'd8});
    repeat (9) @(posedge clk); #2;
    issue(8'hFF, 8'h01, 1'b0, {1'b1, 8'h00});
    repeat (9) @(posedge clk); #2;
    issue(8'd200, 8'd100, 1'b0, {1'b1, 8'h2C});
    repeat (9) @(posedge clk); #2;
    issue(8'd5, 8'd3, 1'b1, {1'b1, 8'd2});
    repeat (9) @(posedge clk); #2;
    issue(8'd3, 8'd5, 1'b1, {1'b0, 8'hFE});
    repeat (9) @(posedge clk); #2;
    issue(8'h80, 8'h80, 1'b0, {1'b1, 8'h00});
    repeat (9) @(posedge clk); #2;

    // Start pulsed while busy must be ignored.
    issue(8'd1, 8'd1, 1'b0, {1'b0, 8'd2});
    repeat (2) @(posedge clk); #2;
    a = 8'h7F; b = 8'h7F; sub = 1'b0; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (8) @(posedge clk); #2;

    // Asynchronous reset mid-operation aborts without a done pulse.
    issue(8'hAA, 8'h55, 1'b0, {1'b0, 8'hFF});
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    q.delete();
    busy_lo  = 1;
    busy_hi  = 0;
    last_sum = 8'h00;
    last_c   = 1'b0;
    #1;
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_sum", {24'd0, sum}, 32'd0);
    chk("async_cout", {31'd0, carry_out}, 32'd0);
    repeat (2) @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    issue(8'h10, 8'h20, 1'b0, {1'b0, 8'h30});
    repeat (12) @(posedge clk); #2;

    chk("queue_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
